// File: rtl/mask_packer.sv
// rtl/mask_packer.sv - packs a byte-per-pixel motion mask into one-bit-per-pixel words and counts foreground per frame
// Optional build macro: MASK_PACKER_INVERT_EN adds an 'invert' input that packs and counts background instead.
module mask_packer #(
    parameter int DATA_WIDTH   = 32,
    parameter int PACK_WIDTH   = 32,
    parameter int FRAME_PIXELS = 442368,
    parameter int CNT_WIDTH    = $clog2(FRAME_PIXELS + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_dout,
    input  logic                  in_empty,
`ifdef MASK_PACKER_INVERT_EN
    input  logic                  invert,
`endif
    output logic                  in_rd_en,
    output logic [PACK_WIDTH-1:0] out_din,
    input  logic                  out_full,
    output logic                  out_wr_en,
    output logic [CNT_WIDTH-1:0]  fg_count,
    output logic                  frame_done
);

    localparam int IDX_WIDTH = $clog2(PACK_WIDTH);

    typedef enum logic [0:0] {S_FILL, S_WRITE} state_t;

    state_t                state, state_nxt;
    logic [PACK_WIDTH-1:0] word;
    logic [IDX_WIDTH-1:0]  bit_idx;
    logic [CNT_WIDTH-1:0]  pix_cnt;
    logic [CNT_WIDTH-1:0]  fg_acc;
    logic                  pix_bit;
    logic                  word_last;
    logic                  frame_last;
    logic                  frame_end;

    // Any non-zero mask byte is foreground; the optional invert flips the sense per pixel.
`ifdef MASK_PACKER_INVERT_EN
    assign pix_bit = invert ? ~(|in_dout) : (|in_dout);
`else
    assign pix_bit = |in_dout;
`endif

    // word_last/frame_last qualify the pixel being popped; frame_end qualifies the word being written
    // (pix_cnt has already counted the final pixel by then).
    assign word_last  = (bit_idx == IDX_WIDTH'(PACK_WIDTH - 1));
    assign frame_last = (pix_cnt == CNT_WIDTH'(FRAME_PIXELS - 1));
    assign frame_end  = (pix_cnt == CNT_WIDTH'(FRAME_PIXELS));

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and FIFO handshakes; the pop is held off while reset is asserted so no pixel is lost.
    always_comb begin
        state_nxt  = state;
        in_rd_en   = 1'b0;
        out_wr_en  = 1'b0;
        out_din    = '0;
        frame_done = 1'b0;
        case (state)
            S_FILL: begin
                if (!in_empty && !reset) begin
                    in_rd_en = 1'b1;
                    if (word_last || frame_last) begin
                        state_nxt = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (!out_full) begin
                    out_wr_en  = 1'b1;
                    out_din    = word;
                    frame_done = frame_end;
                    state_nxt  = S_FILL;
                end
            end
            default: state_nxt = S_FILL;
        endcase
    end

    // Datapath: shift pixels in LSB first, count them, and publish the foreground total at frame end.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word     <= '0;
            bit_idx  <= '0;
            pix_cnt  <= '0;
            fg_acc   <= '0;
            fg_count <= '0;
        end else begin
            if (in_rd_en) begin
                word[bit_idx] <= pix_bit;
                bit_idx       <= bit_idx + IDX_WIDTH'(1);
                pix_cnt       <= pix_cnt + CNT_WIDTH'(1);
                fg_acc        <= fg_acc + CNT_WIDTH'(pix_bit);
            end
            // Clearing the word after each write is what zero-pads a short final word.
            if (out_wr_en) begin
                word    <= '0;
                bit_idx <= '0;
                if (frame_end) begin
                    pix_cnt  <= '0;
                    fg_acc   <= '0;
                    fg_count <= fg_acc;
                end
            end
        end
    end

endmodule

// File: tb/tb_mask_packer.sv
// tb/tb_mask_packer.sv - directed self-checking bench for mask_packer (32-pixel and 40-pixel frame instances)
module tb_mask_packer;

    logic        clock;
    logic        reset;
    logic        sel;
    logic [31:0] in_dout;
    logic        in_empty;
    logic        out_full;
`ifdef MASK_PACKER_INVERT_EN
    logic        invert;
`endif

    logic        a_empty, a_full, a_rd, a_wr, a_fd;
    logic [31:0] a_din;
    logic [5:0]  a_fg;
    logic        b_empty, b_full, b_rd, b_wr, b_fd;
    logic [31:0] b_din;
    logic [5:0]  b_fg;

    logic        rd_sel, wr_sel, fd_sel;
    logic [31:0] din_sel;
    logic [5:0]  fg_sel;

    assign a_empty = sel ? 1'b1 : in_empty;
    assign a_full  = sel ? 1'b0 : out_full;
    assign b_empty = sel ? in_empty : 1'b1;
    assign b_full  = sel ? out_full : 1'b0;
    assign rd_sel  = sel ? b_rd  : a_rd;
    assign wr_sel  = sel ? b_wr  : a_wr;
    assign fd_sel  = sel ? b_fd  : a_fd;
    assign din_sel = sel ? b_din : a_din;
    assign fg_sel  = sel ? b_fg  : a_fg;

    mask_packer #(.DATA_WIDTH(32), .PACK_WIDTH(32), .FRAME_PIXELS(32)) dut_a (
        .clock(clock), .reset(reset), .in_dout(in_dout), .in_empty(a_empty),
`ifdef MASK_PACKER_INVERT_EN
        .invert(invert),
`endif
        .in_rd_en(a_rd), .out_din(a_din), .out_full(a_full), .out_wr_en(a_wr),
        .fg_count(a_fg), .frame_done(a_fd)
    );

    mask_packer #(.DATA_WIDTH(32), .PACK_WIDTH(32), .FRAME_PIXELS(40)) dut_b (
        .clock(clock), .reset(reset), .in_dout(in_dout), .in_empty(b_empty),
`ifdef MASK_PACKER_INVERT_EN
        .invert(invert),
`endif
        .in_rd_en(b_rd), .out_din(b_din), .out_full(b_full), .out_wr_en(b_wr),
        .fg_count(b_fg), .frame_done(b_fd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_pop = 0;
    int wr_cyc = 0;
    int stray_fd = 0;
    int stall_bad = 0;
    logic prev_fd = 1'b0;

    logic [31:0] wq[$];
    logic        fdq[$];
    logic [31:0] fgq[$];
    logic [31:0] ew[$];
    logic        ef[$];
    logic [31:0] eg[$];
    logic [31:0] px[120];
    logic [31:0] tbl[4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        cyc++;
        if (wr_sel) begin
            wq.push_back(din_sel);
            fdq.push_back(fd_sel);
            wr_cyc = cyc;
        end else if (fd_sel) begin
            stray_fd++;
        end
        if (prev_fd) fgq.push_back(32'(fg_sel));
        prev_fd = fd_sel;
    endtask

    task automatic clear_q();
        wq.delete(); fdq.delete(); fgq.delete();
        ew.delete(); ef.delete(); eg.delete();
        stray_fd = 0;
        prev_fd  = 1'b0;
    endtask

    // Offer one pixel until the selected DUT pops it; a pending write may take one cycle first.
    task automatic send(input logic [31:0] v);
        bit done = 1'b0;
        for (int k = 0; k < 4 && !done; k++) begin
            @(negedge clock);
            in_dout = v; in_empty = 1'b0; out_full = 1'b0;
            #1;
            sample();
            if (rd_sel) begin
                done     = 1'b1;
                last_pop = cyc;
            end
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            in_empty = 1'b1; out_full = 1'b0;
            #1;
            sample();
        end
    endtask

    // Full output FIFO while input data is available: nothing may move.
    task automatic stall(input int n, input logic [31:0] v);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            in_dout = v; in_empty = 1'b0; out_full = 1'b1;
            #1;
            if (rd_sel || wr_sel) stall_bad++;
            sample();
        end
    endtask

    task automatic verify(input string tag);
        check({tag, "_nwords"}, wq.size(), ew.size());
        for (int i = 0; i < ew.size(); i++) begin
            if (i < wq.size()) begin
                check($sformatf("%s_word%0d", tag, i), wq[i], ew[i]);
                check($sformatf("%s_done%0d", tag, i), 32'(fdq[i]), 32'(ef[i]));
            end
        end
        check({tag, "_nfg"}, fgq.size(), eg.size());
        for (int i = 0; i < eg.size(); i++) begin
            if (i < fgq.size()) check($sformatf("%s_fg%0d", tag, i), fgq[i], eg[i]);
        end
        check({tag, "_stray_done"}, stray_fd, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int          fg;
        int          drop_cyc;

        reset = 1'b1; sel = 1'b0; in_dout = 32'hFF; in_empty = 1'b0; out_full = 1'b0;
`ifdef MASK_PACKER_INVERT_EN
        invert = 1'b0;
`endif
        tbl[0] = 32'h00; tbl[1] = 32'hFF; tbl[2] = 32'h01; tbl[3] = 32'h80;

        // Reset state, with data available so a pop would be visible.
        @(negedge clock); #1;
        check("rst_rd_en", 32'(a_rd), 32'd0);
        check("rst_wr_en", 32'(a_wr), 32'd0);
        check("rst_din", a_din, 32'd0);
        check("rst_fg", 32'(a_fg), 32'd0);
        check("rst_done", 32'(a_fd), 32'd0);
        @(negedge clock);
        reset = 1'b0; in_empty = 1'b1;

        // Alternating pixels, frame equals one word.
        clear_q();
        for (int i = 0; i < 32; i++) send((i % 2 == 0) ? 32'hFF : 32'h00);
        idle(3);
        ew.push_back(32'h5555_5555); ef.push_back(1'b1); eg.push_back(32'd16);
        verify("alt32");
        check("alt32_latency", wr_cyc, last_pop + 1);

        // 40-pixel frame of foreground: full word then padded word.
        sel = 1'b1;
        clear_q();
        for (int i = 0; i < 40; i++) send(32'hFF);
        idle(3);
        ew.push_back(32'hFFFF_FFFF); ef.push_back(1'b0);
        ew.push_back(32'h0000_00FF); ef.push_back(1'b1);
        eg.push_back(32'd40);
        verify("ones40");

        // Back-pressure across two frames.
        clear_q();
        stall_bad = 0;
        for (int i = 0; i < 32; i++) send((i < 16) ? 32'hFF : 32'h00);
        stall(10, 32'hFF);
        drop_cyc = cyc + 1;
        for (int i = 32; i < 40; i++) send(32'hFF);
        check("stall_write_on_drop", wr_cyc, drop_cyc);
        for (int i = 0; i < 40; i++) send((i == 0) ? 32'h01 : ((i == 39) ? 32'h80 : 32'h00));
        stall(5, 32'hFF);
        idle(3);
        ew.push_back(32'h0000_FFFF); ef.push_back(1'b0);
        ew.push_back(32'h0000_00FF); ef.push_back(1'b1);
        ew.push_back(32'h0000_0001); ef.push_back(1'b0);
        ew.push_back(32'h0000_0080); ef.push_back(1'b1);
        eg.push_back(32'd24); eg.push_back(32'd2);
        verify("stall");
        check("stall_quiet", stall_bad, 0);

        // Random input gaps over three frames against a simple bit-packing model.
        clear_q();
        for (int i = 0; i < 120; i++) px[i] = tbl[$urandom_range(0, 3)];
        for (int f = 0; f < 3; f++) begin
            w = 32'd0; fg = 0;
            for (int i = 0; i < 32; i++) if (px[f*40 + i] != 32'd0) begin w[i] = 1'b1; fg++; end
            ew.push_back(w); ef.push_back(1'b0);
            w = 32'd0;
            for (int i = 32; i < 40; i++) if (px[f*40 + i] != 32'd0) begin w[i-32] = 1'b1; fg++; end
            ew.push_back(w); ef.push_back(1'b1);
            eg.push_back(32'(fg));
        end
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            send(px[i]);
        end
        idle(3);
        verify("gaps");

        // Reset mid-frame discards the partial word and counts.
        clear_q();
        for (int i = 0; i < 20; i++) send(32'h00);
        @(negedge clock);
        reset = 1'b1; in_dout = 32'hFF; in_empty = 1'b0; out_full = 1'b0;
        #1;
        check("midrst_rd_en", 32'(rd_sel), 32'd0);
        check("midrst_wr_en", 32'(wr_sel), 32'd0);
        check("midrst_din", din_sel, 32'd0);
        check("midrst_fg", 32'(fg_sel), 32'd0);
        check("midrst_done", 32'(fd_sel), 32'd0);
        @(negedge clock);
        reset = 1'b0; in_empty = 1'b1;
        clear_q();
        for (int i = 0; i < 40; i++) send(32'hFF);
        idle(3);
        ew.push_back(32'hFFFF_FFFF); ef.push_back(1'b0);
        ew.push_back(32'h0000_00FF); ef.push_back(1'b1);
        eg.push_back(32'd40);
        verify("after_rst");

`ifdef MASK_PACKER_INVERT_EN
        // Inverted decode packs and counts background.
        sel = 1'b0; invert = 1'b1;
        clear_q();
        for (int i = 0; i < 32; i++) send(32'h00);
        idle(3);
        ew.push_back(32'hFFFF_FFFF); ef.push_back(1'b1); eg.push_back(32'd32);
        verify("invert");
        invert = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
